// File: rtl/ctu_clsp_dram_ckenseq.sv
// ctu_clsp_dram_ckenseq: staggered DRAM-domain clock-enable sequencer (optional grst request: CTU_CKENSEQ_GRST_REQ_EN)
module ctu_clsp_dram_ckenseq #(
    parameter int GAP_W    = 4,
    parameter int NUM_CKEN = 6
) (
    input  logic             dram_gclk,
    input  logic             rst,
    input  logic             start_clk_dg,
    input  logic [GAP_W-1:0] stagger_gap,
    input  logic             force_cken,
    output logic             ctu_dram02_dram_cken_dg,
    output logic             ctu_dram13_dram_cken_dg,
    output logic             ctu_ddr0_dram_cken_dg,
    output logic             ctu_ddr1_dram_cken_dg,
    output logic             ctu_ddr2_dram_cken_dg,
    output logic             ctu_ddr3_dram_cken_dg,
    output logic             cken_all_on,
    output logic             cken_all_off,
    output logic             ckenseq_busy
`ifdef CTU_CKENSEQ_GRST_REQ_EN
    ,
    output logic             a_grst_req_dg
`endif
);
    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_UP  = 2'd1;
    localparam logic [1:0] S_ON  = 2'd2;
    localparam logic [1:0] S_DN  = 2'd3;
    localparam logic [2:0] IDX_TOP = 3'(NUM_CKEN - 1);
    logic [1:0]          r_state;
    logic [NUM_CKEN-1:0] r_cken;
    logic [2:0]          r_idx;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_all_on;
    logic                r_all_off;
    logic                r_busy;
    logic [1:0]          w_state_nx;
    logic [NUM_CKEN-1:0] w_cken_nx;
    logic [2:0]          w_idx_nx;
    logic [GAP_W-1:0]    w_gap_nx;
    logic [2:0]          w_idx_up;
    logic [NUM_CKEN-1:0] w_cken_out;
    assign w_idx_up = r_idx + 3'd1;
    // Next-state: one enable change per edge; a level change on start_clk_dg reverses the ramp immediately
    always_comb begin
        w_state_nx = r_state;
        w_cken_nx  = r_cken;
        w_idx_nx   = r_idx;
        w_gap_nx   = r_gap_cnt;
        case (r_state)
            S_OFF: if (start_clk_dg) begin
                w_cken_nx[0] = 1'b1;
                w_idx_nx     = 3'd0;
                w_gap_nx     = stagger_gap;
                w_state_nx   = S_UP;
            end
            S_UP: if (!start_clk_dg) begin
                w_cken_nx[r_idx] = 1'b0;
                w_gap_nx         = stagger_gap;
                w_idx_nx         = (r_idx == 3'd0) ? 3'd0 : r_idx - 3'd1;
                w_state_nx       = (r_idx == 3'd0) ? S_OFF : S_DN;
            end else if (r_gap_cnt != '0) begin
                w_gap_nx = r_gap_cnt - 1'b1;
            end else begin
                w_cken_nx[w_idx_up] = 1'b1;
                w_idx_nx            = w_idx_up;
                w_gap_nx            = stagger_gap;
                w_state_nx          = (w_idx_up == IDX_TOP) ? S_ON : S_UP;
            end
            S_ON: if (!start_clk_dg) begin
                w_cken_nx[IDX_TOP] = 1'b0;
                w_idx_nx           = IDX_TOP - 3'd1;
                w_gap_nx           = stagger_gap;
                w_state_nx         = S_DN;
            end
            S_DN: if (start_clk_dg) begin
                w_cken_nx[w_idx_up] = 1'b1;
                w_idx_nx            = w_idx_up;
                w_gap_nx            = stagger_gap;
                w_state_nx          = (w_idx_up == IDX_TOP) ? S_ON : S_UP;
            end else if (r_gap_cnt != '0) begin
                w_gap_nx = r_gap_cnt - 1'b1;
            end else begin
                w_cken_nx[r_idx] = 1'b0;
                w_gap_nx         = stagger_gap;
                w_idx_nx         = (r_idx == 3'd0) ? 3'd0 : r_idx - 3'd1;
                w_state_nx       = (r_idx == 3'd0) ? S_OFF : S_DN;
            end
            default: w_state_nx = S_OFF;
        endcase
    end
    // Sequencer state and status flags; everything holds while force_cken is asserted
    always_ff @(posedge dram_gclk) begin
        if (rst) begin
            r_state   <= S_OFF;
            r_cken    <= '0;
            r_idx     <= 3'd0;
            r_gap_cnt <= '0;
            r_all_on  <= 1'b0;
            r_all_off <= 1'b1;
            r_busy    <= 1'b0;
        end else if (!force_cken) begin
            r_state   <= w_state_nx;
            r_cken    <= w_cken_nx;
            r_idx     <= w_idx_nx;
            r_gap_cnt <= w_gap_nx;
            r_all_on  <= w_state_nx == S_ON;
            r_all_off <= w_state_nx == S_OFF;
            r_busy    <= w_state_nx == S_UP || w_state_nx == S_DN;
        end
    end
    assign w_cken_out              = r_cken | {NUM_CKEN{force_cken}};
    assign ctu_dram02_dram_cken_dg = w_cken_out[0];
    assign ctu_dram13_dram_cken_dg = w_cken_out[1];
    assign ctu_ddr0_dram_cken_dg   = w_cken_out[2];
    assign ctu_ddr1_dram_cken_dg   = w_cken_out[3];
    assign ctu_ddr2_dram_cken_dg   = w_cken_out[4];
    assign ctu_ddr3_dram_cken_dg   = w_cken_out[5];
    assign cken_all_on             = r_all_on;
    assign cken_all_off            = r_all_off;
    assign ckenseq_busy            = r_busy;
`ifdef CTU_CKENSEQ_GRST_REQ_EN
    logic r_grst_pend;
    logic r_grst;
    // One-cycle grst request the edge after entering ON; held pending while forced
    always_ff @(posedge dram_gclk) begin
        if (rst) begin
            r_grst_pend <= 1'b0;
            r_grst      <= 1'b0;
        end else begin
            r_grst      <= !force_cken && r_grst_pend && r_state == S_ON;
            r_grst_pend <= force_cken ? r_grst_pend : (w_state_nx == S_ON && r_state != S_ON);
        end
    end
    assign a_grst_req_dg = r_grst;
`endif
endmodule

// File: tb/tb_ctu_clsp_dram_ckenseq.sv
// tb_ctu_clsp_dram_ckenseq: directed bench for the DRAM clock-enable sequencer
module tb_ctu_clsp_dram_ckenseq;
    logic       dram_gclk = 1'b0;
    logic       rst = 1'b1;
    logic       start_clk_dg = 1'b0;
    logic [3:0] stagger_gap = 4'd0;
    logic       force_cken = 1'b0;
    logic       dram02, dram13, ddr0, ddr1, ddr2, ddr3;
    logic       all_on, all_off, busy;
    logic [5:0] ck;
    int         n_chk = 0;
    int         n_err = 0;
    int         n;
`ifdef CTU_CKENSEQ_GRST_REQ_EN
    logic       grst;
`endif
    ctu_clsp_dram_ckenseq dut (
        .dram_gclk               (dram_gclk),
        .rst                     (rst),
        .start_clk_dg            (start_clk_dg),
        .stagger_gap             (stagger_gap),
        .force_cken              (force_cken),
        .ctu_dram02_dram_cken_dg (dram02),
        .ctu_dram13_dram_cken_dg (dram13),
        .ctu_ddr0_dram_cken_dg   (ddr0),
        .ctu_ddr1_dram_cken_dg   (ddr1),
        .ctu_ddr2_dram_cken_dg   (ddr2),
        .ctu_ddr3_dram_cken_dg   (ddr3),
        .cken_all_on             (all_on),
        .cken_all_off            (all_off),
        .ckenseq_busy            (busy)
`ifdef CTU_CKENSEQ_GRST_REQ_EN
        ,
        .a_grst_req_dg           (grst)
`endif
    );
    assign ck = {ddr3, ddr2, ddr1, ddr0, dram13, dram02};
    always #5 dram_gclk = ~dram_gclk;
    task automatic step();
        @(posedge dram_gclk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    initial begin
        int t3 [12];
        t3 = '{1, 1, 1, 1, 3, 3, 1, 1, 1, 1, 0, 0};
        // reset state
        step();
        chk("rst_cken", {26'd0, ck}, 32'h0);
        chk("rst_off", {31'd0, all_off}, 1);
        chk("rst_on", {31'd0, all_on}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        // ramp up with gap 2: enable k rises 1+3k edges after the request
        rst = 1'b0;
        stagger_gap = 4'd2;
        start_clk_dg = 1'b1;
        for (int r = 1; r <= 18; r++) begin
            step();
            n = (r - 1) / 3 + 1;
            if (n > 6) n = 6;
            chk($sformatf("up_g2_e%0d", r), {26'd0, ck}, (1 << n) - 1);
            chk($sformatf("up_g2_busy_e%0d", r), {31'd0, busy}, (r < 16) ? 1 : 0);
            chk($sformatf("up_g2_on_e%0d", r), {31'd0, all_on}, (r >= 16) ? 1 : 0);
        end
        // ramp down with gap 0: one enable falls per edge, highest first
        stagger_gap = 4'd0;
        start_clk_dg = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            step();
            n = (r >= 6) ? 0 : 6 - r;
            chk($sformatf("dn_g0_e%0d", r), {26'd0, ck}, (1 << n) - 1);
            chk($sformatf("dn_g0_off_e%0d", r), {31'd0, all_off}, (r >= 6) ? 1 : 0);
            chk($sformatf("dn_g0_busy_e%0d", r), {31'd0, busy}, (r < 6) ? 1 : 0);
        end
        // gap 3, request up then dropped mid-ramp
        stagger_gap = 4'd3;
        start_clk_dg = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            step();
            chk($sformatf("rev_e%0d", r), {26'd0, ck}, t3[r-1]);
            chk($sformatf("rev_off_e%0d", r), {31'd0, all_off}, (r >= 11) ? 1 : 0);
            if (r == 6) start_clk_dg = 1'b0;
        end
        // force during ramp-up with two enables set
        stagger_gap = 4'd2;
        start_clk_dg = 1'b1;
        repeat (4) step();
        chk("frc_pre", {26'd0, ck}, 32'h3);
        force_cken = 1'b1;
        #1;
        chk("frc_now", {26'd0, ck}, 32'h3f);
        for (int r = 1; r <= 4; r++) begin
            step();
            chk($sformatf("frc_hold_e%0d", r), {26'd0, ck}, 32'h3f);
            chk($sformatf("frc_busy_e%0d", r), {31'd0, busy}, 1);
        end
        force_cken = 1'b0;
        #1;
        chk("frc_rel", {26'd0, ck}, 32'h3);
        step();
        step();
        chk("frc_gap", {26'd0, ck}, 32'h3);
        step();
        chk("frc_resume", {26'd0, ck}, 32'h7);
        // reset mid-ramp with four enables set, then restart
        rst = 1'b1;
        step();
        rst = 1'b0;
        stagger_gap = 4'd0;
        start_clk_dg = 1'b1;
        repeat (4) step();
        chk("mr_pre", {26'd0, ck}, 32'hf);
        rst = 1'b1;
        step();
        chk("mr_cken", {26'd0, ck}, 32'h0);
        chk("mr_off", {31'd0, all_off}, 1);
        chk("mr_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        step();
        chk("mr_restart1", {26'd0, ck}, 32'h1);
        step();
        chk("mr_restart2", {26'd0, ck}, 32'h3);
`ifdef CTU_CKENSEQ_GRST_REQ_EN
        // grst pulse one edge after reaching ON
        rst = 1'b1;
        start_clk_dg = 1'b0;
        step();
        rst = 1'b0;
        start_clk_dg = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            step();
            chk($sformatf("grst_e%0d", r), {31'd0, grst}, (r == 7) ? 1 : 0);
        end
        // same with force held over edges 7..9: pulse deferred to edge 10
        rst = 1'b1;
        start_clk_dg = 1'b0;
        step();
        rst = 1'b0;
        start_clk_dg = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            step();
            chk($sformatf("grst_frc_e%0d", r), {31'd0, grst}, (r == 10) ? 1 : 0);
            if (r == 6) force_cken = 1'b1;
            if (r == 9) force_cken = 1'b0;
        end
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
